narrow_saturate: RTL and testbench

Streaming width reducer: the inverse direction of the datapath's 16→32 sign extension. Accepts 32-bit signed results on a valid/ready stream, narrows each to 16 bits by truncation, signed saturation or unsigned clamp, and flags beats whose value did not fit. It sits between the ALU/image-processing result path and 16-bit pixel/halfword storage. It also keeps a running count of overflowed beats.

---
 rtl/narrow_saturate_pkg.sv | 37 +++
 rtl/narrow_saturate_if.sv | 33 +++
 rtl/narrow_saturate_core.sv | 66 ++++++
 rtl/narrow_saturate.sv | 105 ++++++++++
 tb/tb_narrow_saturate.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/narrow_saturate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : narrow_pkg
// Purpose  : Shared types for the narrow_saturate streaming width reducer.
//            - mode_e   : narrowing mode carried with every beat
//            - beat_t   : {data, ovf} record at the default 16-bit output width
//            - decode_mode : maps the raw 2-bit mode field onto mode_e
//                            (the spare encoding 2'b11 aliases signed saturate)
// Revision : 1.0  initial release
// ============================================================================
package narrow_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC = 2'b00,
        MODE_SSAT  = 2'b01,
        MODE_USAT  = 2'b10
    } mode_e;

    localparam int c_beat_dw = 16;

    typedef struct packed {
        logic [c_beat_dw-1:0] data;
        logic                 ovf;
    } beat_t;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b00:   m = MODE_TRUNC;
            2'b10:   m = MODE_USAT;
            default: m = MODE_SSAT;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/narrow_saturate_if.sv
`default_nettype none
// ============================================================================
// Module   : narrow_saturate_if
// Purpose  : Input and output valid/ready streams of narrow_saturate.
//            in_*  : 32-bit signed words plus 2-bit mode, upstream -> block
//            out_* : narrowed word plus overflow flag, block -> downstream
//            master modport = stream source/sink side, slave = the block.
// Revision : 1.0  initial release
// ============================================================================
interface narrow_saturate_if #(
    parameter int INPUT_DWIDTH  = 32,
    parameter int OUTPUT_DWIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [INPUT_DWIDTH-1:0]  in_data;
    logic [1:0]               in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUTPUT_DWIDTH-1:0] out_data;
    logic                     out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/narrow_saturate_core.sv
`default_nettype none
// ============================================================================
// Module   : narrow_core
// Purpose  : Combinational narrowing of one signed word.
//            i_data : INPUT_DWIDTH signed word
//            i_mode : raw 2-bit mode (trunc / signed sat / unsigned clamp)
//            o_data : OUTPUT_DWIDTH narrowed word
//            o_ovf  : value not representable in the selected mode
// Revision : 1.0  initial release
// ============================================================================
module narrow_core
    import narrow_pkg::*;
#(
    parameter int INPUT_DWIDTH  = 32,
    parameter int OUTPUT_DWIDTH = 16
) (
    input  wire logic [INPUT_DWIDTH-1:0]  i_data,
    input  wire logic [1:0]               i_mode,
    output logic      [OUTPUT_DWIDTH-1:0] o_data,
    output logic                          o_ovf
);
    localparam logic [OUTPUT_DWIDTH-1:0] c_smax = {1'b0, {(OUTPUT_DWIDTH-1){1'b1}}};
    localparam logic [OUTPUT_DWIDTH-1:0] c_smin = {1'b1, {(OUTPUT_DWIDTH-1){1'b0}}};
    localparam logic [OUTPUT_DWIDTH-1:0] c_umax = {OUTPUT_DWIDTH{1'b1}};

    mode_e w_mode;
    logic  w_neg;
    logic  w_fits_signed;
    logic  w_fits_unsigned;

    assign w_mode = decode_mode(i_mode);
    assign w_neg  = i_data[INPUT_DWIDTH-1];

    // Fits as signed when every bit from the output sign bit upward matches.
    assign w_fits_signed   = (&i_data[INPUT_DWIDTH-1:OUTPUT_DWIDTH-1]) |
                             ~(|i_data[INPUT_DWIDTH-1:OUTPUT_DWIDTH-1]);
    // Fits as unsigned when nothing above the output width is set
    // (this also rejects negative values).
    assign w_fits_unsigned = ~(|i_data[INPUT_DWIDTH-1:OUTPUT_DWIDTH]);

    always_comb begin
        o_data = i_data[OUTPUT_DWIDTH-1:0];
        o_ovf  = 1'b0;
        case (w_mode)
            MODE_TRUNC: begin
                o_ovf = ~w_fits_signed;
            end
            MODE_USAT: begin
                if (w_neg) begin
                    o_data = '0;
                    o_ovf  = 1'b1;
                end else if (!w_fits_unsigned) begin
                    o_data = c_umax;
                    o_ovf  = 1'b1;
                end
            end
            default: begin
                if (!w_fits_signed) begin
                    o_data = w_neg ? c_smin : c_smax;
                    o_ovf  = 1'b1;
                end
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/narrow_saturate.sv
`default_nettype none
// ============================================================================
// Module   : narrow_saturate
// Purpose  : Streaming 32->16 width reducer with a two-entry skid buffer and
//            a saturating count of delivered overflow beats.
//            clk, rst  : clock, synchronous active-high reset
//            bus       : narrow_saturate_if.slave (in_* / out_* streams)
//            clr_count : synchronous clear of ovf_count (beats increment)
//            ovf_count : delivered beats with out_ovf=1, holds at all-ones
// Revision : 1.0  initial release
// ============================================================================
module narrow_saturate
    import narrow_pkg::*;
#(
    parameter int INPUT_DWIDTH  = 32,
    parameter int OUTPUT_DWIDTH = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    narrow_saturate_if.slave            bus,
    input  wire logic                   clr_count,
    output logic      [COUNT_WIDTH-1:0] ovf_count
);
    typedef struct packed {
        logic [OUTPUT_DWIDTH-1:0] data;
        logic                     ovf;
    } store_t;

    store_t                   w_in_beat;
    logic [OUTPUT_DWIDTH-1:0] w_nar_data;
    logic                     w_nar_ovf;
    logic                     w_in_fire;
    logic                     w_out_fire;

    store_t                   r_main;
    store_t                   r_skid;
    logic                     r_main_valid;
    logic                     r_skid_valid;
    logic                     r_in_ready;
    logic [COUNT_WIDTH-1:0]   r_count;

    // Narrowing happens before storage so the mode travels with its beat.
    narrow_core #(
        .INPUT_DWIDTH  (INPUT_DWIDTH),
        .OUTPUT_DWIDTH (OUTPUT_DWIDTH)
    ) u_core (
        .i_data (bus.in_data),
        .i_mode (bus.in_mode),
        .o_data (w_nar_data),
        .o_ovf  (w_nar_ovf)
    );

    assign w_in_beat.data = w_nar_data;
    assign w_in_beat.ovf  = w_nar_ovf;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_main_valid & bus.out_ready;

    // Main register feeds the output; skid catches the one beat that can
    // arrive while the main register is stalled. in_ready mirrors skid-empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_main_valid || w_out_fire) begin
            // in_ready is low whenever skid is occupied, so no new beat can
            // compete with the skid reload.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_fire) begin
                r_main       <= w_in_beat;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_in_beat;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    // Clear takes priority over a coincident overflow delivery.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            r_count <= '0;
        end else if (w_out_fire && r_main.ovf && (r_count != {COUNT_WIDTH{1'b1}})) begin
            r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main.data;
    assign bus.out_ovf   = r_main.ovf;
    assign ovf_count     = r_count;
endmodule
`default_nettype wire

// File: tb/tb_narrow_saturate.sv
`default_nettype none
// ============================================================================
// Module   : tb_narrow_saturate
// Purpose  : Self-checking bench for narrow_saturate. Expected beats are
//            queued when the input handshake is seen; a monitor records
//            delivered beats; each test task compares the two queues.
//            A second instance with a 3-bit counter exercises counter
//            saturation in a few cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_narrow_saturate;
    import narrow_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_count = 1'b0;
    logic        clr2 = 1'b0;
    logic [15:0] ovf_count;
    logic [2:0]  ovf_count2;

    narrow_saturate_if #(.INPUT_DWIDTH(32), .OUTPUT_DWIDTH(16)) bus ();
    narrow_saturate_if #(.INPUT_DWIDTH(32), .OUTPUT_DWIDTH(16)) bus2 ();

    narrow_saturate #(.INPUT_DWIDTH(32), .OUTPUT_DWIDTH(16), .COUNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    narrow_saturate #(.INPUT_DWIDTH(32), .OUTPUT_DWIDTH(16), .COUNT_WIDTH(3)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .clr_count (clr2),
        .ovf_count (ovf_count2)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always @(negedge clk) begin
        beat_t b;
        if (!rst && bus.out_valid && bus.out_ready) begin
            b.data = bus.out_data;
            b.ovf  = bus.out_ovf;
            obs_q.push_back(b);
        end
    end

    // Independent reference for the narrowing rules.
    function automatic beat_t model(input logic [31:0] d, input logic [1:0] m);
        beat_t  b;
        longint v;
        v      = longint'($signed(d));
        b.data = d[15:0];
        b.ovf  = 1'b0;
        case (m)
            2'b00: b.ovf = (v > 32767) || (v < -32768);
            2'b10: begin
                if (v < 0)          begin b.data = 16'h0000; b.ovf = 1'b1; end
                else if (v > 65535) begin b.data = 16'hFFFF; b.ovf = 1'b1; end
            end
            default: begin
                if (v > 32767)       begin b.data = 16'h7FFF; b.ovf = 1'b1; end
                else if (v < -32768) begin b.data = 16'h8000; b.ovf = 1'b1; end
            end
        endcase
        return b;
    endfunction

    // Offers one beat starting at posedge+1; returns at posedge+1 after accept.
    task automatic send_beat(input logic [31:0] d, input logic [1:0] m, input beat_t e);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) begin
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready, bus.out_ovf} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_flags: got valid/ready/ovf=%b required 010",
                     {bus.out_valid, bus.in_ready, bus.out_ovf});
        end
        n_vec++;
        if (bus.out_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: got %h required 0000", bus.out_data);
        end
        n_vec++;
        if (ovf_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_count: got %h required 0000", ovf_count);
        end
    endtask

    task automatic test_narrowing();
        logic [31:0] td [9] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
                                32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF,
                                32'h1234_5678, 32'hFFFF_FFFE};
        logic [1:0]  tm [9] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [15:0] te [9] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
                                16'hFFFF, 16'hFFFF, 16'h0000, 16'h5678, 16'hFFFE};
        logic        to [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        beat_t e, o;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        // First beat alone: presented the cycle after acceptance.
        e.data = te[0];
        e.ovf  = to[0];
        send_beat(td[0], tm[0], e);
        idle();
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency: out_valid=%b one cycle after accept, required 1", bus.out_valid);
        end
        @(posedge clk);
        #1;
        for (int i = 1; i < 9; i++) begin
            e.data = te[i];
            e.ovf  = to[i];
            send_beat(td[i], tm[i], e);
        end
        idle();
        wait_out();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL narrow_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL narrow_beat: got %h/%b required %h/%b", o.data, o.ovf, e.data, e.ovf);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t       e, o;
        logic [15:0] held;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_beat(32'h0000_0100 + 32'(i), 2'b01, model(32'h0000_0100 + 32'(i), 2'b01));
                end
                idle();
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                held = bus.out_data;
                @(negedge clk);
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_in_ready: got %b with 2 beats buffered, required 0", bus.in_ready);
                end
                @(negedge clk);
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    n_bad++;
                    $display("FAIL bp_stable: got valid=%b data=%h required valid=1 data=%h",
                             bus.out_valid, bus.out_data, held);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_out();
        n_vec++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            n_bad++;
            $display("FAIL bp_count: got %0d beats required 8", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL bp_order: got %h/%b required %h/%b", o.data, o.ovf, e.data, e.ovf);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_counter();
        beat_t e, o;
        @(posedge clk); #1;
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        bus.out_ready = 1'b1;
        e.data = 16'h5678;
        e.ovf  = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(32'h1234_5678, 2'b00, e);
        idle();
        wait_out();
        n_vec++;
        if (ovf_count !== 16'd5) begin
            n_bad++;
            $display("FAIL count_five: got %0d required 5", ovf_count);
        end
        // Overflow beat parked in main, then delivered in the clear cycle.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        e.data = 16'h7FFF;
        send_beat(32'h0001_8000, 2'b01, e);
        idle();
        clr_count     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovf_count !== 16'd0) begin
            n_bad++;
            $display("FAIL count_clr_wins: got %0d required 0", ovf_count);
        end
        wait_out();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL count_beats: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL count_beat: got %h/%b required %h/%b", o.data, o.ovf, e.data, e.ovf);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_count_saturate();
        @(posedge clk); #1;
        bus2.in_data  = 32'h1234_5678;
        bus2.in_mode  = 2'b00;
        bus2.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ovf_count2 !== 3'd3) begin
            n_bad++;
            $display("FAIL sat_count_mid: got %0d required 3", ovf_count2);
        end
        repeat (10) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ovf_count2 !== 3'h7) begin
            n_bad++;
            $display("FAIL sat_count_hold: got %0d required 7", ovf_count2);
        end
    endtask

    task automatic test_reset_midstream();
        beat_t e, o;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        e.data = 16'h0000;
        e.ovf  = 1'b1;
        send_beat(32'h8000_0000, 2'b10, e);
        idle();
        wait_out();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rstm_pre_beat: got %h/%b required %h/%b", o.data, o.ovf, e.data, e.ovf);
            end
        end
        n_vec++;
        if (ovf_count !== 16'd1) begin
            n_bad++;
            $display("FAIL rstm_pre_count: got %0d required 1", ovf_count);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send_beat(32'h7000_0000, 2'b01, model(32'h7000_0000, 2'b01));
        send_beat(32'h0000_1111, 2'b00, model(32'h0000_1111, 2'b00));
        idle();
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rstm_full: in_ready=%b with 2 buffered, required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01 || ovf_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rstm_state: got valid/ready=%b count=%0d required 01 and 0",
                     {bus.out_valid, bus.in_ready}, ovf_count);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL rstm_discard: got %0d stale beats required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_mode_switch();
        logic [31:0] vals [8] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
                                  32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h8000_0001};
        logic [31:0] d;
        logic [1:0]  m;
        beat_t e, o;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = (i < 8) ? vals[(i * 3) % 8] : $urandom();
            m = 2'(i);
            send_beat(d, m, model(d, m));
        end
        idle();
        wait_out();
        n_vec++;
        if (obs_q.size() != 16 || exp_q.size() != 16) begin
            n_bad++;
            $display("FAIL mode_count: got %0d beats required 16", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL mode_beat: got %h/%b required %h/%b", o.data, o.ovf, e.data, e.ovf);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_mode    = 2'b00;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.in_mode   = 2'b00;
        bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_narrowing();
        test_backpressure();
        test_counter();
        test_count_saturate();
        test_reset_midstream();
        test_mode_switch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
